pwm_duty_capture: RTL and testbench
===================================

// Module: pwm_duty_capture
// PURPOSE
// - Receive-side counterpart of the motor PWM generator: measures high time and period of one incoming PWM line.
// - Uses the same 10 us tick grid (500 clk at 50 MHz) and 2000-tick / 20 ms nominal frame.
// - Checks generated duty at motor driver input (loopback), or decodes an external PWM command.
// - Reports each completed frame plus stuck-line and period-error status.
// PARAMETERS
// - TICK_DIV      500   clk cycles per measurement tick (10 us at 50 MHz)
// - CNT_W         12    width of tick counters and result ports
// - NOMINAL_TICKS 2000  expected PWM period in ticks
// - PERIOD_TOL    20    allowed |period - NOMINAL_TICKS| before period_err is set
// - TIMEOUT_TICKS 4000  ticks without a rising edge before the line is declared stuck (< 2^CNT_W)
// PORTS
// - clk           in   1      system clock, 50 MHz
// - rst           in   1      asynchronous, active-high reset
// - pwm_in        in   1      asynchronous PWM input
// - high_ticks    out  CNT_W  high time of last frame, in ticks
// - period_ticks  out  CNT_W  rising-to-rising period of last frame, in ticks (0 on stuck report)
// - meas_valid    out  1      one-clk pulse: outputs updated this cycle
// - period_err    out  1      last frame period outside NOMINAL_TICKS +/- PERIOD_TOL
// - stuck         out  1      last report was a timeout; stays set until next good frame
// - stuck_level   out  1      sampled pwm_in level at the timeout
// BEHAVIOUR
// - Reset: all outputs 0; FSM IDLE; tick, high and period counters 0; sync flops 0.
// - pwm_in passes a 2-flop synchronizer. Tick strobe: 1 clk when tick counter = TICK_DIV-1, then counter wraps to 0.
// - Sampling: only on tick. prev_s holds the previous tick sample. rise = s & ~prev_s; fall = ~s & prev_s.
// - FSM states IDLE, HIGH, LOW. All transitions and counting occur on tick only.
// - IDLE:
//   - on rise: hi_cnt=1, per_cnt=1, go to HIGH; no report.
//   - otherwise per_cnt++.
// - HIGH:
//   - s=1: hi_cnt++, per_cnt++.
//   - fall: per_cnt++, go to LOW.
// - LOW:
//   - s=0: per_cnt++.
//   - rise: report frame, then hi_cnt=1, per_cnt=1, stay in the frame loop (go to HIGH).
// - Frame report (same clk as the rise tick, registered outputs):
//   - high_ticks=hi_cnt, period_ticks=per_cnt, meas_valid=1 for one clk.
//   - period_err = |per_cnt - NOMINAL_TICKS| > PERIOD_TOL; stuck=0.
// - Timeout, any state, on a tick with no rise and per_cnt = TIMEOUT_TICKS-1:
//   - report stuck=1, stuck_level=s, high_ticks = s ? TIMEOUT_TICKS : 0, period_ticks=0, period_err=1, meas_valid=1.
//   - go to IDLE with per_cnt=0; repeats every TIMEOUT_TICKS ticks while the line stays static.
// - Tie rule: rise on the timeout tick counts as a rise; no timeout is reported.
// - Counter widths: per_cnt and hi_cnt never exceed TIMEOUT_TICKS, so no wrap. Compute the difference at CNT_W+1 bits, signed.
// - Latency: edge at pwm_in to sampled = 2 clk sync + up to TICK_DIV clk tick quantization. Measurement resolution is +/-1 tick.
// - First rise after reset or IDLE only arms the FSM; first report is at the end of the first complete frame.
// - Reset mid-frame: asynchronous clear of everything; a partial frame is discarded.
// - Pulses shorter than 1 tick may be missed; this is accepted behaviour.
// STRUCTURE
// - Shared package (pwm_pkg): PWM_TICK_DIV=500, PWM_NOMINAL_TICKS=2000, PWM_CNT_W=12, duty constants 2000/1961/1725/1176, FSM state enum.
// - Sub-module pwm_tick_gen (clk, rst -> tick): divider shared with the generator side.
// - Top level: synchronizer, edge detect, FSM, and output registers.
// TESTING (TICK_DIV=4 in simulation, other parameters default)
// - Reset, no input activity: all outputs 0; at TIMEOUT_TICKS: meas_valid, stuck=1, stuck_level=0, high_ticks=0.
// - 1176 high / 2000 period, 3 frames: first report after frame 1 completes; high_ticks=1176, period_ticks=2000, period_err=0, stuck=0.
// - 2000 high / 2000 period, then pwm_in held 1: timeout report with stuck_level=1, high_ticks=4000; later frames clear stuck.
// - Period 2030, high 490: period_err=1, high_ticks=490. Period 2015: period_err=0.
// - Assert rst mid-HIGH (hi_cnt ~ 800): outputs clear immediately; the next report needs one full new frame.
// - Rise exactly on the timeout tick: no stuck report; the frame continues normally.

Source files
------------

// File: rtl/pwm_pkg.sv
// Shared PWM constants and types for the motor PWM generator and its capture side.
// Contents: tick divider, nominal frame length, counter width, standard duty values
// (in ticks of high time per 2000-tick frame) and the capture FSM state type.
package pwm_pkg;

    localparam int unsigned PWM_TICK_DIV      = 500;   // 10 us tick at 50 MHz
    localparam int unsigned PWM_NOMINAL_TICKS = 2000;  // 20 ms frame
    localparam int unsigned PWM_CNT_W         = 12;

    // Standard duty settings, high time in ticks
    localparam int unsigned PWM_DUTY_FULL = 2000;
    localparam int unsigned PWM_DUTY_HIGH = 1961;
    localparam int unsigned PWM_DUTY_MID  = 1725;
    localparam int unsigned PWM_DUTY_LOW  = 1176;

    typedef enum logic [1:0] {
        StIdle,
        StHigh,
        StLow
    } cap_state_e;

endpackage

// File: rtl/pwm_tick_gen.sv
// Measurement tick divider, shared with the PWM generator side.
// Ports:
//   clk  - system clock
//   rst  - asynchronous active-high reset
//   tick - one-clk strobe every TICK_DIV clocks (while counter = TICK_DIV-1)
module pwm_tick_gen
    import pwm_pkg::*;
#(
    parameter int unsigned TICK_DIV = PWM_TICK_DIV
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int unsigned           CntW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CntW-1:0]       Last = CntW'(TICK_DIV - 1);

    logic [CntW-1:0] cnt_q;

    assign tick = (cnt_q == Last);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (tick) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + CntW'(1);
        end
    end

endmodule

// File: rtl/pwm_duty_capture.sv
// Receive-side PWM measurement: high time and rising-to-rising period of one PWM line,
// quantised to the shared measurement tick, with stuck-line and period-error status.
// Ports:
//   clk          - system clock (50 MHz)
//   rst          - asynchronous active-high reset
//   pwm_in       - asynchronous PWM input
//   high_ticks   - high time of last frame in ticks (TIMEOUT_TICKS or 0 on a stuck report)
//   period_ticks - period of last frame in ticks (0 on a stuck report)
//   meas_valid   - one-clk pulse when the outputs above were updated
//   period_err   - last period outside NOMINAL_TICKS +/- PERIOD_TOL (always set when stuck)
//   stuck        - last report was a timeout; cleared by the next good frame
//   stuck_level  - synchronised line level sampled at the last timeout
module pwm_duty_capture
    import pwm_pkg::*;
#(
    parameter int unsigned TICK_DIV      = PWM_TICK_DIV,
    parameter int unsigned CNT_W         = PWM_CNT_W,
    parameter int unsigned NOMINAL_TICKS = PWM_NOMINAL_TICKS,
    parameter int unsigned PERIOD_TOL    = 20,
    parameter int unsigned TIMEOUT_TICKS = 4000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pwm_in,
    output logic [CNT_W-1:0] high_ticks,
    output logic [CNT_W-1:0] period_ticks,
    output logic             meas_valid,
    output logic             period_err,
    output logic             stuck,
    output logic             stuck_level
);

    localparam logic [CNT_W-1:0]        TimeoutLast = CNT_W'(TIMEOUT_TICKS - 1);
    localparam logic [CNT_W-1:0]        TimeoutFull = CNT_W'(TIMEOUT_TICKS);
    localparam logic signed [CNT_W:0]   NominalS    = (CNT_W+1)'(NOMINAL_TICKS);
    localparam logic signed [CNT_W:0]   TolS        = (CNT_W+1)'(PERIOD_TOL);

    logic               tick;
    logic               sync_meta_q;
    logic               sync_q;
    logic               prev_s_q;
    cap_state_e         state_q;
    logic [CNT_W-1:0]   hi_cnt_q;
    logic [CNT_W-1:0]   per_cnt_q;

    logic               s;
    logic               rise;
    logic               fall;
    logic               timeout;
    logic signed [CNT_W:0] per_diff;
    logic               per_out_of_tol;

    pwm_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_gen (
        .clk  (clk),
        .rst  (rst),
        .tick (tick)
    );

    // Two-flop synchroniser for the asynchronous line
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_meta_q <= 1'b0;
            sync_q      <= 1'b0;
        end else begin
            sync_meta_q <= pwm_in;
            sync_q      <= sync_meta_q;
        end
    end

    // Edges are defined between consecutive tick samples, not between clocks
    assign s    = sync_q;
    assign rise = s & ~prev_s_q;
    assign fall = ~s & prev_s_q;

    // A rise on the timeout tick wins: the line is evidently not stuck
    assign timeout = ~rise & (per_cnt_q == TimeoutLast);

    // Counters never exceed TIMEOUT_TICKS, so one extra bit holds the signed difference
    assign per_diff       = $signed({1'b0, per_cnt_q}) - NominalS;
    assign per_out_of_tol = (per_diff > TolS) || (per_diff < -TolS);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_s_q     <= 1'b0;
            state_q      <= StIdle;
            hi_cnt_q     <= '0;
            per_cnt_q    <= '0;
            high_ticks   <= '0;
            period_ticks <= '0;
            meas_valid   <= 1'b0;
            period_err   <= 1'b0;
            stuck        <= 1'b0;
            stuck_level  <= 1'b0;
        end else begin
            meas_valid <= 1'b0;
            if (tick) begin
                prev_s_q <= s;
                if (timeout) begin
                    high_ticks   <= s ? TimeoutFull : '0;
                    period_ticks <= '0;
                    period_err   <= 1'b1;
                    stuck        <= 1'b1;
                    stuck_level  <= s;
                    meas_valid   <= 1'b1;
                    hi_cnt_q     <= '0;
                    per_cnt_q    <= '0;
                    state_q      <= StIdle;
                end else begin
                    unique case (state_q)
                        StIdle: begin
                            // First rise only arms; there is no complete frame yet
                            if (rise) begin
                                hi_cnt_q  <= CNT_W'(1);
                                per_cnt_q <= CNT_W'(1);
                                state_q   <= StHigh;
                            end else begin
                                per_cnt_q <= per_cnt_q + CNT_W'(1);
                            end
                        end
                        StHigh: begin
                            per_cnt_q <= per_cnt_q + CNT_W'(1);
                            if (fall) begin
                                state_q <= StLow;
                            end else begin
                                hi_cnt_q <= hi_cnt_q + CNT_W'(1);
                            end
                        end
                        StLow: begin
                            if (rise) begin
                                high_ticks   <= hi_cnt_q;
                                period_ticks <= per_cnt_q;
                                period_err   <= per_out_of_tol;
                                stuck        <= 1'b0;
                                meas_valid   <= 1'b1;
                                hi_cnt_q     <= CNT_W'(1);
                                per_cnt_q    <= CNT_W'(1);
                                state_q      <= StHigh;
                            end else begin
                                per_cnt_q <= per_cnt_q + CNT_W'(1);
                            end
                        end
                        default: begin
                            state_q <= StIdle;
                        end
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_pwm_duty_capture.sv
module tb_pwm_duty_capture;

    localparam int unsigned TICK_DIV = 4;
    localparam int unsigned CNT_W    = 12;
    localparam int          NOMINAL  = 2000;
    localparam int          TOL      = 20;
    localparam int          TIMEOUT  = 4000;

    logic             clk = 1'b0;
    logic             rst;
    logic             pwm_in;
    logic [CNT_W-1:0] high_ticks;
    logic [CNT_W-1:0] period_ticks;
    logic             meas_valid;
    logic             period_err;
    logic             stuck;
    logic             stuck_level;

    pwm_duty_capture #(
        .TICK_DIV (TICK_DIV)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .pwm_in       (pwm_in),
        .high_ticks   (high_ticks),
        .period_ticks (period_ticks),
        .meas_valid   (meas_valid),
        .period_err   (period_err),
        .stuck        (stuck),
        .stuck_level  (stuck_level)
    );

    always #10 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model, in terms of tick indices since reset:
    //   period = distance between consecutive rises, high = fall index - rise index,
    //   a stuck report fires when TIMEOUT ticks pass with no rise since the last rise
    //   or the last stuck report (reset counts as a stuck report at tick 0).
    int t;
    int m_anchor;
    int m_rise;
    int m_fall;
    bit m_prev;
    bit m_armed;
    bit exp_valid;
    int exp_high;
    int exp_period;
    bit exp_err;
    bit exp_stuck;
    bit exp_level;
    bit extra_pulse;

    logic wave[$];

    function automatic logic [2*CNT_W+2:0] got_fields();
        return {high_ticks, period_ticks, period_err, stuck, stuck_level};
    endfunction

    function automatic logic [2*CNT_W+2:0] exp_fields();
        return {CNT_W'(exp_high), CNT_W'(exp_period), exp_err, exp_stuck, exp_level};
    endfunction

    function automatic string fmt_got();
        return $sformatf("valid=%0b extra=%0b high=%0d per=%0d err=%0b stuck=%0b lvl=%0b",
                         meas_valid, extra_pulse, high_ticks, period_ticks, period_err,
                         stuck, stuck_level);
    endfunction

    function automatic string fmt_exp();
        return $sformatf("valid=%0b extra=0 high=%0d per=%0d err=%0b stuck=%0b lvl=%0b",
                         exp_valid, exp_high, exp_period, exp_err, exp_stuck, exp_level);
    endfunction

    task automatic model_reset();
        t         = 0;
        m_anchor  = 1;
        m_rise    = 0;
        m_fall    = 0;
        m_prev    = 1'b0;
        m_armed   = 1'b0;
        exp_valid = 1'b0;
        exp_high  = 0;
        exp_period = 0;
        exp_err   = 1'b0;
        exp_stuck = 1'b0;
        exp_level = 1'b0;
    endtask

    task automatic add_level(input logic v, input int n);
        for (int i = 0; i < n; i++) wave.push_back(v);
    endtask

    task automatic add_frame(input int high, input int period);
        add_level(1'b1, high);
        add_level(1'b0, period - high);
    endtask

    // Drive one tick period of pwm_in, finish #1 after the tick edge, advance the model
    task automatic step(input logic v);
        bit rise;
        bit fall;
        pwm_in      = v;
        extra_pulse = 1'b0;
        for (int k = 0; k < TICK_DIV; k++) begin
            @(posedge clk);
            #1;
            if (k < TICK_DIV - 1 && meas_valid !== 1'b0) extra_pulse = 1'b1;
        end
        t++;
        rise      = v && !m_prev;
        fall      = !v && m_prev;
        exp_valid = 1'b0;
        if (rise) begin
            if (m_armed) begin
                exp_valid  = 1'b1;
                exp_high   = m_fall - m_rise;
                exp_period = t - m_rise;
                exp_err    = (exp_period > NOMINAL + TOL) || (exp_period < NOMINAL - TOL);
                exp_stuck  = 1'b0;
            end
            m_armed  = 1'b1;
            m_rise   = t;
            m_anchor = t;
        end else if (t - m_anchor == TIMEOUT - 1) begin
            exp_valid  = 1'b1;
            exp_stuck  = 1'b1;
            exp_level  = v;
            exp_high   = v ? TIMEOUT : 0;
            exp_period = 0;
            exp_err    = 1'b1;
            m_armed    = 1'b0;
            m_anchor   = t + 1;
        end
        if (fall) m_fall = t;
        m_prev = v;
    endtask

    task automatic test_reset();
        rst    = 1'b1;
        pwm_in = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if ({high_ticks, period_ticks, meas_valid, period_err, stuck, stuck_level} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %s, required all zero", fmt_got());
        end
        rst = 1'b0;
        model_reset();
        wave = {};
        add_level(1'b0, TIMEOUT);
        foreach (wave[i]) begin
            step(wave[i]);
            n_checks++;
            if (meas_valid !== exp_valid || extra_pulse ||
                (exp_valid && got_fields() !== exp_fields())) begin
                n_fail++;
                $display("FAIL idle_model t=%0d: got %s, required %s", t, fmt_got(), fmt_exp());
            end
        end
        n_checks++;
        if (meas_valid !== 1'b1 || stuck !== 1'b1 || stuck_level !== 1'b0 ||
            high_ticks !== 0 || period_ticks !== 0 || period_err !== 1'b1) begin
            n_fail++;
            $display("FAIL idle_stuck_low t=%0d: got %s, required valid stuck lvl=0 high=0 per=0",
                     t, fmt_got());
        end
    endtask

    task automatic test_reset_mid_frame();
        wave = {};
        add_level(1'b0, 5);
        add_level(1'b1, 800);
        foreach (wave[i]) begin
            step(wave[i]);
            n_checks++;
            if (meas_valid !== exp_valid || extra_pulse ||
                (exp_valid && got_fields() !== exp_fields())) begin
                n_fail++;
                $display("FAIL arm_model t=%0d: got %s, required %s", t, fmt_got(), fmt_exp());
            end
        end
        rst = 1'b1;
        #1;
        n_checks++;
        if ({high_ticks, period_ticks, meas_valid, period_err, stuck, stuck_level} !== '0) begin
            n_fail++;
            $display("FAIL reset_mid_high: got %s, required all zero", fmt_got());
        end
        pwm_in = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    // Rise exactly on the tick that would otherwise time out, then a full frame
    task automatic test_tie();
        int reports;
        reports = 0;
        wave = {};
        add_level(1'b0, TIMEOUT - 1);
        add_frame(1176, 2000);
        foreach (wave[i]) begin
            step(wave[i]);
            n_checks++;
            if (meas_valid !== exp_valid || extra_pulse ||
                (exp_valid && got_fields() !== exp_fields())) begin
                n_fail++;
                $display("FAIL tie_model t=%0d: got %s, required %s", t, fmt_got(), fmt_exp());
            end
            if (meas_valid === 1'b1) reports++;
        end
        n_checks++;
        if (reports != 0 || stuck !== 1'b0) begin
            n_fail++;
            $display("FAIL tie_no_report: got %0d reports stuck=%0b, required 0 reports stuck=0",
                     reports, stuck);
        end
    endtask

    task automatic test_duty();
        int reports;
        reports = 0;
        wave = {};
        repeat (2) add_frame(1176, 2000);
        foreach (wave[i]) begin
            step(wave[i]);
            n_checks++;
            if (meas_valid !== exp_valid || extra_pulse ||
                (exp_valid && got_fields() !== exp_fields())) begin
                n_fail++;
                $display("FAIL duty_model t=%0d: got %s, required %s", t, fmt_got(), fmt_exp());
            end
            if (meas_valid === 1'b1) begin
                reports++;
                n_checks++;
                if (high_ticks !== 1176 || period_ticks !== 2000 || period_err !== 1'b0 ||
                    stuck !== 1'b0 || i % 2000 != 0) begin
                    n_fail++;
                    $display("FAIL duty_report idx=%0d: got %s, required high=1176 per=2000",
                             i, fmt_got());
                end
            end
        end
        n_checks++;
        if (reports != 2) begin
            n_fail++;
            $display("FAIL duty_report_count: got %0d, required 2", reports);
        end
    endtask

    task automatic test_period_err();
        wave = {};
        add_frame(490, 2030);
        add_frame(490, 2015);
        add_level(1'b1, 1);
        foreach (wave[i]) begin
            step(wave[i]);
            n_checks++;
            if (meas_valid !== exp_valid || extra_pulse ||
                (exp_valid && got_fields() !== exp_fields())) begin
                n_fail++;
                $display("FAIL period_model t=%0d: got %s, required %s", t, fmt_got(), fmt_exp());
            end
            if (i == 2030) begin
                n_checks++;
                if (meas_valid !== 1'b1 || high_ticks !== 490 || period_ticks !== 2030 ||
                    period_err !== 1'b1) begin
                    n_fail++;
                    $display("FAIL period_2030: got %s, required high=490 per=2030 err=1",
                             fmt_got());
                end
            end
            if (i == 4045) begin
                n_checks++;
                if (meas_valid !== 1'b1 || high_ticks !== 490 || period_ticks !== 2015 ||
                    period_err !== 1'b0) begin
                    n_fail++;
                    $display("FAIL period_2015: got %s, required high=490 per=2015 err=0",
                             fmt_got());
                end
            end
        end
    endtask

    // Line held high after a rise until it times out, then short frames recover
    task automatic test_stuck_high();
        int p;
        wave = {};
        add_level(1'b1, TIMEOUT + 3);
        add_level(1'b0, 6);
        repeat (2) begin
            p = $urandom_range(40, 10);
            add_frame($urandom_range(p - 1, 1), p);
        end
        add_level(1'b1, 1);
        foreach (wave[i]) begin
            step(wave[i]);
            n_checks++;
            if (meas_valid !== exp_valid || extra_pulse ||
                (exp_valid && got_fields() !== exp_fields())) begin
                n_fail++;
                $display("FAIL stuck_model t=%0d: got %s, required %s", t, fmt_got(), fmt_exp());
            end
            if (i == TIMEOUT - 2) begin
                n_checks++;
                if (meas_valid !== 1'b1 || stuck !== 1'b1 || stuck_level !== 1'b1 ||
                    high_ticks !== TIMEOUT || period_ticks !== 0 || period_err !== 1'b1) begin
                    n_fail++;
                    $display("FAIL stuck_high: got %s, required stuck lvl=1 high=4000 per=0",
                             fmt_got());
                end
            end
        end
        n_checks++;
        if (meas_valid !== 1'b1 || stuck !== 1'b0) begin
            n_fail++;
            $display("FAIL stuck_cleared: got %s, required valid=1 stuck=0", fmt_got());
        end
    endtask

    task automatic test_random();
        int p;
        wave = {};
        repeat (12) begin
            p = $urandom_range(40, 3);
            add_frame($urandom_range(p - 1, 1), p);
        end
        add_level(1'b1, 1);
        foreach (wave[i]) begin
            step(wave[i]);
            n_checks++;
            if (meas_valid !== exp_valid || extra_pulse ||
                (exp_valid && got_fields() !== exp_fields())) begin
                n_fail++;
                $display("FAIL random_model t=%0d: got %s, required %s", t, fmt_got(), fmt_exp());
            end
        end
    endtask

    initial begin
        test_reset();
        test_reset_mid_frame();
        test_tie();
        test_duty();
        test_period_err();
        test_stuck_high();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
